// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared widths, FSM state and shift mode types for shift_seq
package shift_seq_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROL = 2'd3
    } mode_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step with carry out
module shift_step
    import shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0] y_i,
    input  mode_e             mode_i,
    output logic [DATA_W-1:0] y_o,
    output logic              c_o
);

    always_comb begin
        y_o = y_i;
        c_o = 1'b0;
        case (mode_i)
            SLL: begin
                y_o = {y_i[DATA_W-2:0], 1'b0};
                c_o = y_i[DATA_W-1];
            end
            SRL: begin
                y_o = {1'b0, y_i[DATA_W-1:1]};
                c_o = y_i[0];
            end
            SRA: begin
                y_o = {y_i[DATA_W-1], y_i[DATA_W-1:1]};
                c_o = y_i[0];
            end
            ROL: begin
                y_o = {y_i[DATA_W-2:0], y_i[DATA_W-1]};
                c_o = y_i[DATA_W-1];
            end
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle shifter FSM; SHIFT_SEQ_ROTATE_EN adds rotate-left (lr=0, la=1)
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [CNT_W-1:0]  amt,
    input  logic              la,
    input  logic              lr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] y,
    output logic              c,
    output logic              z
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d, accept_mode;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  y_q, y_d, step_y;
    logic               c_q, c_d, step_c, z_q;

    shift_step u_step (
        .y_i    (y_q),
        .mode_i (mode_q),
        .y_o    (step_y),
        .c_o    (step_c)
    );

    always_comb begin
        if (lr) begin
            accept_mode = la ? SRA : SRL;
        end else begin
`ifdef SHIFT_SEQ_ROTATE_EN
            accept_mode = la ? ROL : SLL;
`else
            accept_mode = SLL;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    y_d     = a;
                    cnt_d   = amt;
                    mode_d  = accept_mode;
                    c_d     = 1'b0;
                    state_d = (amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                y_d   = step_y;
                c_d   = step_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // z is registered from y_d so it always tracks the y register exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= SLL;
            cnt_q   <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            c_q     <= c_d;
            z_q     <= (y_d == '0);
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign y    = y_q;
    assign c    = c_q;
    assign z    = z_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - directed self-checking bench for shift_seq
module tb_shift_seq;

    logic       clk, reset, start, la, lr;
    logic [7:0] a;
    logic [2:0] amt;
    logic       busy, done, c, z;
    logic [7:0] y;
    int         errors = 0;
    int         checks = 0;
    int         lat;

    shift_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .amt   (amt),
        .la    (la),
        .lr    (lr),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .c     (c),
        .z     (z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or bound expires).
    task automatic run_op(input logic [7:0] ai, input logic [2:0] ni,
                          input logic lai, input logic lri, output int latency);
        start = 1'b1; a = ai; amt = ni; la = lai; lr = lri;
        @(posedge clk);
        #1;
        start = 1'b0; a = 8'hA5; amt = 3'd6; la = ~lai; lr = ~lri;
        latency = 0;
        @(negedge clk);
        while (!done && latency < 16) begin
            @(posedge clk);
            latency++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output int latency);
        latency = 0;
        while (!done && latency < 16) begin
            @(posedge clk);
            latency++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = 8'h00; amt = 3'd0; la = 1'b0; lr = 1'b0;
        #12;
        check("rst_y", y, 8'h00);
        check("rst_c", c, 1'b0);
        check("rst_z", z, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // SRA 0x96 by 3: 0xCB -> 0xE5 -> 0xF2, last bit out 1
        run_op(8'h96, 3'd3, 1'b1, 1'b1, lat);
        check("sra_lat", lat, 3);
        check("sra_done", done, 1'b1);
        check("sra_busy", busy, 1'b1);
        check("sra_y", y, 8'hF2);
        check("sra_c", c, 1'b1);
        check("sra_z", z, 1'b0);
        @(negedge clk);
        check("sra_done_1cyc", done, 1'b0);
        check("sra_idle_busy", busy, 1'b0);
        check("sra_hold_y", y, 8'hF2);
        check("sra_hold_c", c, 1'b1);

        run_op(8'h01, 3'd1, 1'b0, 1'b1, lat);
        check("srl1_lat", lat, 1);
        check("srl1_y", y, 8'h00);
        check("srl1_c", c, 1'b1);
        check("srl1_z", z, 1'b1);
        @(negedge clk);

        // amt=0: done right after acceptance, y=a, c cleared from previous 1
        run_op(8'h5A, 3'd0, 1'b1, 1'b1, lat);
        check("amt0_lat", lat, 0);
        check("amt0_done", done, 1'b1);
        check("amt0_y", y, 8'h5A);
        check("amt0_c", c, 1'b0);
        @(negedge clk);

        run_op(8'h81, 3'd1, 1'b1, 1'b0, lat);
        check("lsh_la_lat", lat, 1);
`ifdef SHIFT_SEQ_ROTATE_EN
        check("lsh_la_y", y, 8'h03);
`else
        check("lsh_la_y", y, 8'h02);
`endif
        check("lsh_la_c", c, 1'b1);
        @(negedge clk);

        run_op(8'h81, 3'd1, 1'b0, 1'b0, lat);
        check("sll_y", y, 8'h02);
        check("sll_c", c, 1'b1);
        @(negedge clk);

        // Reset in the middle of SRL 0x80 by 7
        start = 1'b1; a = 8'h80; amt = 3'd7; la = 1'b0; lr = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("mrst_y", y, 8'h00);
        check("mrst_c", c, 1'b0);
        check("mrst_z", z, 1'b1);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", busy, 1'b0);
        run_op(8'h80, 3'd7, 1'b0, 1'b1, lat);
        check("rerun_lat", lat, 7);
        check("rerun_y", y, 8'h01);
        check("rerun_c", c, 1'b0);
        check("rerun_z", z, 1'b0);
        @(negedge clk);

        // Back-to-back with start held high: SLL 0x0F by 2 then SRA 0xF0 by 2
        start = 1'b1; a = 8'h0F; amt = 3'd2; la = 1'b0; lr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wait_done(lat);
        check("b2b1_lat", lat, 2);
        check("b2b1_y", y, 8'h3C);
        check("b2b1_c", c, 1'b0);
        a = 8'hF0; amt = 3'd2; la = 1'b1; lr = 1'b1;
        @(negedge clk);
        check("b2b_idle_busy", busy, 1'b0);
        check("b2b_idle_done", done, 1'b0);
        check("b2b_idle_y", y, 8'h3C);
        @(negedge clk);
        check("b2b_accepted", busy, 1'b1);
        check("b2b_acc_y", y, 8'hF0);
        // start toggling and operand changes while shifting must be ignored
        start = 1'b0; a = 8'h00; amt = 3'd0; la = 1'b0; lr = 1'b0;
        #2 start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("b2b2_lat", lat, 1);
        check("b2b2_y", y, 8'hFC);
        check("b2b2_c", c, 1'b0);
        check("b2b2_z", z, 1'b0);
        @(negedge clk);
        check("b2b_end_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
